pwm_multi: RTL and testbench

- Parametrised N-channel PWM generator; successor to the two-channel gen_PWM plus the fixed gen8MHz/gen1MHz enable generators.
- Contains an internal programmable prescaler, one shared period counter, and per-channel duty compare.
- Uses double-buffered period/duty registers, loaded through a request/acknowledge handshake and applied only at a period boundary, so outputs never glitch mid-period.
- Sits beside the receivers in top; its outputs drive the photonic switch drivers.

---
 rtl/pwm_multi.sv | 192 +++++++++++++++++++
 tb/tb_pwm_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi -- N-channel PWM generator with a shared prescaled period counter
// and double-buffered period/duty registers.
//
// Build option: define PWM_CENTER_EN for up/down (centre-aligned) counting.
// Without it the counter runs in up mode only.
//
// Ports:
//   clk        core clock
//   reset      asynchronous, active-high reset
//   en         run enable; low holds prescaler/counter at 0 and outputs low
//   div        prescaler setting; one count tick every div+1 clk cycles
//   period_in  requested period (counter counts 0..period_in)
//   duty_in    requested duties, channel i at bits [i*CW +: CW]
//   load_req   capture period_in/duty_in into the shadow registers
//   load_busy  a captured shadow value is waiting for the next wrap
//   load_ack   one-cycle pulse when the shadow values become active
//   sync       one-cycle pulse at each period wrap
//   pwm_out    registered PWM outputs
module pwm_multi #(
    parameter int NCH   = 4,
    parameter int CW    = 7,
    parameter int DIV_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [CW-1:0]     period_in,
    input  logic [NCH*CW-1:0] duty_in,
    input  logic              load_req,
    output logic              load_busy,
    output logic              load_ack,
    output logic              sync,
    output logic [NCH-1:0]    pwm_out
);

    logic [DIV_W-1:0]  pre_q, pre_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     per_act_q, per_act_d;
    logic [CW-1:0]     per_sh_q, per_sh_d;
    logic [NCH*CW-1:0] duty_act_q, duty_act_d;
    logic [NCH*CW-1:0] duty_sh_q, duty_sh_d;
    logic              pending_q, pending_d;
    logic              sync_q, sync_d;
    logic              ack_q, ack_d;
    logic [NCH-1:0]    pwm_q, pwm_d;
    logic              tick;
    logic              wrap;
`ifdef PWM_CENTER_EN
    logic              dir_down_q, dir_down_d;
`endif

    // tick can only occur while enabled, so wrap (and with it sync, the
    // shadow transfer and load_ack) is implicitly suppressed when en is low.
    assign tick = en && (pre_q == div);

    // Prescaler. If div is lowered below pre, pre simply runs on and wraps
    // at 2^DIV_W before matching again.
    always_comb begin
        pre_d = pre_q;
        if (!en || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + DIV_W'(1);
        end
    end

`ifdef PWM_CENTER_EN
    // Up/down counter. The wrap event is the bottom turn: a tick taken while
    // counting down at cnt == 0. Period 0 pins cnt at 0 and wraps every tick.
    always_comb begin
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        wrap       = 1'b0;
        if (!en) begin
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else if (tick) begin
            if (per_act_q == '0) begin
                cnt_d      = '0;
                dir_down_d = 1'b0;
                wrap       = 1'b1;
            end else if (dir_down_q) begin
                if (cnt_q == '0) begin
                    cnt_d      = CW'(1);
                    dir_down_d = 1'b0;
                    wrap       = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end else begin
                if (cnt_q >= per_act_q) begin
                    cnt_d      = cnt_q - CW'(1);
                    dir_down_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end
`else
    // Up counter, wrapping to 0 on the tick that finds cnt == active period.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == per_act_q) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end
`endif

    // Shadow/active registers. Transfer uses the pending flag as it was
    // before this edge, so a capture coinciding with a wrap is applied one
    // period later. The two branches are mutually exclusive on pending_q.
    always_comb begin
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        per_sh_d   = per_sh_q;
        duty_sh_d  = duty_sh_q;
        pending_d  = pending_q;
        ack_d      = 1'b0;
        sync_d     = wrap;
        if (wrap && pending_q) begin
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
            pending_d  = 1'b0;
            ack_d      = 1'b1;
        end
        if (load_req && !pending_q) begin
            per_sh_d  = period_in;
            duty_sh_d = duty_in;
            pending_d = 1'b1;
        end
    end

    // Per-channel compare. duty 0 never matches (constant low); duty above
    // the period always matches (constant high).
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cmp
            assign pwm_d[gi] = en && (cnt_q < duty_act_q[gi*CW +: CW]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            cnt_q      <= '0;
            per_act_q  <= '1;
            duty_act_q <= '0;
            per_sh_q   <= '1;
            duty_sh_q  <= '0;
            pending_q  <= 1'b0;
            sync_q     <= 1'b0;
            ack_q      <= 1'b0;
            pwm_q      <= '0;
        end else begin
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            pending_q  <= pending_d;
            sync_q     <= sync_d;
            ack_q      <= ack_d;
            pwm_q      <= pwm_d;
        end
    end

`ifdef PWM_CENTER_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_down_q <= 1'b0;
        end else begin
            dir_down_q <= dir_down_d;
        end
    end
`endif

    assign load_busy = pending_q;
    assign load_ack  = ack_q;
    assign sync      = sync_q;
    assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi. Inputs are driven and outputs sampled
// on the falling clock edge; each step checks hand-computed values.
module tb_pwm_multi;
    localparam int NCH   = 4;
    localparam int CW    = 7;
    localparam int DIV_W = 5;
    localparam int BOUND = 600;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [DIV_W-1:0]  div;
    logic [CW-1:0]     period_in;
    logic [NCH*CW-1:0] duty_in;
    logic              load_req;
    logic              load_busy;
    logic              load_ack;
    logic              sync;
    logic [NCH-1:0]    pwm_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_multi #(.NCH(NCH), .CW(CW), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .div       (div),
        .period_in (period_in),
        .duty_in   (duty_in),
        .load_req  (load_req),
        .load_busy (load_busy),
        .load_ack  (load_ack),
        .sync      (sync),
        .pwm_out   (pwm_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Pulse load_req for one rising edge.
    task automatic load(input logic [CW-1:0] p, input logic [NCH*CW-1:0] d);
        period_in = p;
        duty_in   = d;
        load_req  = 1'b1;
        @(negedge clk);
        load_req  = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!load_ack && n < BOUND);
    endtask

    task automatic wait_sync(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync && n < BOUND);
    endtask

    // All channels share one duty: high for the first hi samples, sync on last.
    task automatic run_period(input string tag, input int len, input int hi);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            chk({tag, "_pwm"}, pwm_out, (k <= hi) ? {NCH{1'b1}} : {NCH{1'b0}});
            chk({tag, "_sync"}, sync, (k == len) ? 1 : 0);
        end
    endtask

    initial begin
        int n;
        int hi_cnt;
        logic [NCH-1:0] e;

        reset     = 1'b1;
        en        = 1'b0;
        div       = '0;
        period_in = '0;
        duty_in   = '0;
        load_req  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_sync", sync, 0);
        chk("rst_ack", load_ack, 0);
        chk("rst_busy", load_busy, 0);
        reset = 1'b0;

`ifndef PWM_CENTER_EN
        // Basic PWM: period 9, duties {15,10,3,0} (ch3..ch0).
        load(7'd9, {7'd15, 7'd10, 7'd3, 7'd0});
        chk("basic_busy", load_busy, 1);
        en = 1'b1;
        wait_ack(n);
        chk("basic_ack_lat", n, 128);
        chk("basic_ack_sync", sync, 1);
        @(negedge clk);
        chk("basic_busy_clr", load_busy, 0);
        // first sample above already consumed k=1
        hi_cnt = 1;
        chk("basic_k1_pwm", pwm_out, 4'b1110);
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            e = {1'b1, 1'b1, (((k - 1) % 10) < 3), 1'b0};
            if (pwm_out[1]) hi_cnt++;
            chk("basic_pwm", pwm_out, e);
            chk("basic_sync", sync, (k % 10 == 0) ? 1 : 0);
        end
        chk("basic_ch1_high", hi_cnt, 6);

        // Handshake: second request while pending is ignored.
        load(7'd9, {NCH{7'd5}});
        chk("hs_busy", load_busy, 1);
        load(7'd9, {NCH{7'd7}});
        chk("hs_busy_hold", load_busy, 1);
        wait_ack(n);
        chk("hs_ack_lat", n, 8);
        chk("hs_ack_sync", sync, 1);
        run_period("hs_d5", 10, 5);

        // Request coincident with a wrap is applied one period later.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("co_pre_pwm", pwm_out, (k <= 5) ? 4'hF : 4'h0);
        end
        load(7'd9, {NCH{7'd2}});
        chk("co_sync", sync, 1);
        chk("co_no_ack", load_ack, 0);
        chk("co_busy", load_busy, 1);
        wait_ack(n);
        chk("co_ack_lat", n, 10);
        run_period("co_d2", 10, 2);

        // en toggle with a pending shadow.
        load(7'd9, {NCH{7'd4}});
        chk("en_pre_pwm", pwm_out, 4'hF);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_pwm", pwm_out, 0);
        chk("en_off_sync", sync, 0);
        chk("en_off_busy", load_busy, 1);
        repeat (3) @(negedge clk);
        chk("en_idle_pwm", pwm_out, 0);
        en = 1'b1;
        wait_ack(n);
        chk("en_ack_lat", n, 10);
        run_period("en_d4", 10, 4);

        // Prescaler: div 4, period 3, duty 2.
        en = 1'b0;
        load(7'd3, {NCH{7'd2}});
        div = 5'd4;
        en  = 1'b1;
        wait_ack(n);
        chk("pre_ack_lat", n, 50);
        run_period("pre", 20, 10);

        // Asynchronous reset mid-run.
        load(7'd3, {NCH{7'd2}});
        chk("ar_busy", load_busy, 1);
        chk("ar_pwm", pwm_out, 4'hF);
        #2 reset = 1'b1;
        #1;
        chk("ar_rst_pwm", pwm_out, 0);
        chk("ar_rst_busy", load_busy, 0);
        chk("ar_rst_sync", sync, 0);
        chk("ar_rst_ack", load_ack, 0);
        @(negedge clk);
        div   = '0;
        reset = 1'b0;
        wait_sync(n);
        chk("ar_first_sync", n, 128);
        wait_sync(n);
        chk("ar_period_127", n, 128);
        chk("ar_pwm_low", pwm_out, 0);
`else
        // Centre-aligned: period 4, duty 2 -> 8 clk period, 3 high samples.
        load(7'd4, {NCH{7'd2}});
        en = 1'b1;
        wait_ack(n);
        chk("ctr_ack_lat", n, 255);
        for (int k = 1; k <= 16; k++) begin
            int kk;
            kk = ((k - 1) % 8) + 1;
            @(negedge clk);
            chk("ctr_pwm", pwm_out, (kk == 1 || kk >= 7) ? 4'hF : 4'h0);
            chk("ctr_sync", sync, (kk == 8) ? 1 : 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
